// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift/rotate unit.
package shift_pkg;

    // Operation encodings; 3'b101..3'b111 are unencoded and flagged as illegal.
    localparam logic [2:0] SH_SHR  = 3'b000;
    localparam logic [2:0] SH_SHRA = 3'b001;
    localparam logic [2:0] SH_SHL  = 3'b010;
    localparam logic [2:0] SH_ROR  = 3'b011;
    localparam logic [2:0] SH_ROL  = 3'b100;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

    // True for every encoded operation.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= SH_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts or rotates WIDTH bits by 0..STEP positions
// and reports the last bit that left the word (0 when amt is 0).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 6
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] data_out,
    output logic             out_bit
);

    logic out_right;
    logic out_left;

    // Right shifts lose bit (amt-1); left shifts lose bit (WIDTH-amt). The padding bit
    // makes amt==0 report 0 without any index arithmetic.
    always_comb begin
        out_right = 1'({data_in, 1'b0} >> amt);
        out_left  = 1'(({1'b0, data_in} << amt) >> WIDTH);
        data_out  = data_in;
        out_bit   = 1'b0;
        case (op)
            SH_SHR: begin
                data_out = data_in >> amt;
                out_bit  = out_right;
            end
            SH_SHRA: begin
                data_out = WIDTH'($signed(data_in) >>> amt);
                out_bit  = out_right;
            end
            SH_SHL: begin
                data_out = data_in << amt;
                out_bit  = out_left;
            end
            SH_ROR: begin
                data_out = WIDTH'({data_in, data_in} >> amt);
                out_bit  = out_right;
            end
            SH_ROL: begin
                data_out = WIDTH'(({data_in, data_in} << amt) >> WIDTH);
                out_bit  = out_left;
            end
            default: begin
                data_out = data_in;
                out_bit  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: shifts up to STEP bits per cycle until the requested
// amount is consumed, then pulses done with the result and the last bit shifted out.
//
// Handshake: start is sampled only while ready (IDLE or DONE); op, operand and shamt are
// captured on that edge only. busy is high for every SHIFT cycle. done is a one-cycle pulse
// in which result, carry_out and illegal_op are valid; done and busy are never high together.
// result holds from done until the next accepted start. start while busy is dropped.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic               illegal_op,
    output shift_state_e       state_dbg
);

    // One extra bit so that STEP == WIDTH still fits in the step amount.
    localparam int AMT_W = SHAMT_W + 1;
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    shift_state_e       state_q, state_d;
    logic [WIDTH-1:0]   work_q;
    logic [2:0]         op_q;
    logic [SHAMT_W-1:0] rem_q;
    logic               carry_q;
    logic               illegal_q;

    logic               accept;
    logic [AMT_W-1:0]   rem_ext;
    logic [AMT_W-1:0]   step_amt;
    logic [SHAMT_W-1:0] rem_after;
    logic [WIDTH-1:0]   step_data;
    logic               step_out;

    // Step size this cycle is min(STEP, remaining); rem_after is what is left after it.
    always_comb begin
        rem_ext   = {1'b0, rem_q};
        step_amt  = (rem_ext < STEP_AMT) ? rem_ext : STEP_AMT;
        rem_after = SHAMT_W'(rem_ext - step_amt);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .data_in  (work_q),
        .op       (op_q),
        .amt      (step_amt),
        .data_out (step_data),
        .out_bit  (step_out)
    );

    // Next-state logic; a start in DONE is accepted exactly like one in IDLE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ((shamt != '0) && op_is_legal(op)) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                state_d = (rem_after != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ((shamt != '0) && op_is_legal(op)) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; clear abandons any shift in progress.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Working register, op latch, remaining count and flags.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            work_q    <= '0;
            op_q      <= SH_SHR;
            rem_q     <= '0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            work_q    <= operand;
            op_q      <= op;
            rem_q     <= shamt;
            carry_q   <= 1'b0;
            illegal_q <= !op_is_legal(op);
        end else if (state_q == ST_SHIFT) begin
            work_q  <= step_data;
            rem_q   <= rem_after;
            carry_q <= step_out;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign result     = work_q;
    assign carry_out  = carry_q;
    assign illegal_op = done && illegal_q;
    assign state_dbg  = state_q;

endmodule
